// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM port among NR requesters, in-order response routing.
// Optional per-requester stall counters are enabled with `define TCDM_ARB_PERF_EN.
module tcdm_rr_arbiter #(
    parameter int unsigned NR              = 3,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NR-1:0]                req_i,
    input  logic [NR-1:0][AW-1:0]        add_i,
    input  logic [NR-1:0]                wen_i,
    input  logic [NR-1:0][DW/8-1:0]      be_i,
    input  logic [NR-1:0][DW-1:0]        data_i,
    output logic [NR-1:0]                gnt_o,
    output logic [NR-1:0][DW-1:0]        r_data_o,
    output logic [NR-1:0]                r_valid_o,
    output logic                         mem_req_o,
    output logic [AW-1:0]                mem_add_o,
    output logic                         mem_wen_o,
    output logic [DW/8-1:0]              mem_be_o,
    output logic [DW-1:0]                mem_data_o,
    input  logic                         mem_gnt_i,
    input  logic [DW-1:0]                mem_r_data_i,
    input  logic                         mem_r_valid_i,
    output logic                         err_o
`ifdef TCDM_ARB_PERF_EN
    ,
    output logic [NR-1:0][31:0]          stall_cnt_o
`endif
);

    localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] rr_q;
    logic [IW-1:0] winner;
    logic          found;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [IW-1:0] head;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic          err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from rr_q upward; candidate index stays below 2*NR so one subtract wraps it.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] cand;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NR) idx = idx - NR;
            cand = IW'(idx);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign mem_req_o  = (|req_i) & ~fifo_full;
    assign accept     = mem_req_o & mem_gnt_i;
    assign push       = accept;
    assign pop        = mem_r_valid_i & ~fifo_empty;
    assign head       = fifo_q[rd_ptr_q];
    assign err_o      = err_q;

    assign mem_add_o  = found ? add_i[winner]  : '0;
    assign mem_wen_o  = found ? wen_i[winner]  : 1'b0;
    assign mem_be_o   = found ? be_i[winner]   : '0;
    assign mem_data_o = found ? data_i[winner] : '0;

    always_comb begin
        gnt_o = '0;
        if (accept) gnt_o[winner] = 1'b1;
    end

    for (genvar i = 0; i < NR; i++) begin : g_resp
        assign r_valid_o[i] = pop & (head == IW'(i));
        assign r_data_o[i]  = mem_r_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                rr_q <= (winner == IW'(NR - 1)) ? '0 : winner + 1'b1;
            end
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (mem_r_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) fifo_q[k] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end

`ifdef TCDM_ARB_PERF_EN
    logic [NR-1:0][31:0] stall_q;

    for (genvar i = 0; i < NR; i++) begin : g_perf
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_q[i] <= '0;
            end else if (req_i[i] && !gnt_o[i] && (stall_q[i] != 32'hFFFF_FFFF)) begin
                stall_q[i] <= stall_q[i] + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule
